// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-memory responder for the pipelined processor's data port. Holds a
// word-addressed RAM (addresses 0..DEPTH-1), an LED register at LED_ADDR and
// a read-only switch port at SW_ADDR. Every access is stretched by a number
// of wait states so the processor's Memory-stage stall path gets exercised.
//
// Optional feature (macro DMEM_LFSR_WAIT_EN): a 4-bit maximal LFSR
// (x^4+x^3+1, seeded 4'b0001 on Reset) advances on each accepted request and
// adds lfsr[1:0] extra wait states to the access. Without the macro the wait
// count is always WAIT_CYCLES.
//
// Timing: DataWaitreq is high for (wait count + 1) cycles from the first
// request cycle, then low for exactly one cycle (DONE). The access itself
// happens on the last high cycle, using the address, data and request kind
// present on that cycle.
module data_mem_responder #(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   DEPTH       = 256,
    parameter int                   WAIT_CYCLES = 2,
    parameter logic [WORD_SIZE-1:0] LED_ADDR    = 16'h1000,
    parameter logic [WORD_SIZE-1:0] SW_ADDR     = 16'h3000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    input  logic [WORD_SIZE-1:0] Switches,
    output logic [WORD_SIZE-1:0] Leds,
    output logic                 AccessErr
);

    localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_SIZE:0] DEPTH_W = (WORD_SIZE + 1)'(DEPTH);

    localparam logic [1:0] REG_RAM = 2'd0;
    localparam logic [1:0] REG_LED = 2'd1;
    localparam logic [1:0] REG_SW  = 2'd2;
    localparam logic [1:0] REG_BAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Maps an address onto the RAM, LED, switch or unmapped region.
    function automatic logic [1:0] decode_region(input logic [WORD_SIZE-1:0] addr);
        logic [1:0] region;
        if ({1'b0, addr} < DEPTH_W) begin
            region = REG_RAM;
        end else if (addr == LED_ADDR) begin
            region = REG_LED;
        end else if (addr == SW_ADDR) begin
            region = REG_SW;
        end else begin
            region = REG_BAD;
        end
        return region;
    endfunction

    // Next value of the x^4+x^3+1 Fibonacci LFSR.
    function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
        return {cur[2:0], cur[3] ^ cur[2]};
    endfunction

    state_t               state_r;
    logic [4:0]           counter_r;
    logic [WORD_SIZE-1:0] mem_r [DEPTH];

    logic                 req_s;
    logic [4:0]           wait_s;
    logic                 access_s;
    logic [1:0]           region_s;
    logic [AW-1:0]        ram_idx_s;
    logic [WORD_SIZE-1:0] ram_word_s;

`ifdef DMEM_LFSR_WAIT_EN
    logic [3:0] lfsr_r;

    // Wait-state LFSR, stepped once for every request accepted in IDLE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            lfsr_r <= 4'b0001;
        end else if (state_r == IDLE && req_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Wait count for the request being accepted: base plus 0..3 random extra.
    always_comb begin
        wait_s = 5'(WAIT_CYCLES) + {3'b000, lfsr_r[1:0]};
    end
`else
    // Wait count for the request being accepted: fixed base.
    always_comb begin
        wait_s = 5'(WAIT_CYCLES);
    end
`endif

    // Request decode and the strobe marking the cycle the access is carried out.
    always_comb begin
        req_s      = ReadData | WriteData;
        region_s   = decode_region(DataAddr);
        ram_idx_s  = DataAddr[AW-1:0];
        ram_word_s = mem_r[ram_idx_s];
        access_s   = 1'b0;
        case (state_r)
            IDLE:    access_s = req_s && (wait_s == 5'd0);
            BUSY:    access_s = req_s && (counter_r == 5'd0);
            DONE:    access_s = 1'b0;
            default: access_s = 1'b0;
        endcase
    end

    // Stall the processor until the DONE cycle; no stall without a request.
    assign DataWaitreq = req_s && (state_r != DONE);

    // RAM array; contents deliberately survive Reset, but no write lands in a reset cycle.
    always_ff @(posedge Clock) begin
        if (!Reset && access_s && WriteData && region_s == REG_RAM) begin
            mem_r[ram_idx_s] <= DataOut;
        end
    end

    // Access FSM together with the registered read data, LED register and sticky error.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= IDLE;
            counter_r <= 5'd0;
            DataIn    <= {WORD_SIZE{1'b0}};
            Leds      <= {WORD_SIZE{1'b0}};
            AccessErr <= 1'b0;
        end else begin
            if (access_s) begin
                if (WriteData) begin
                    // Simultaneous read+write is served as a write but flagged.
                    if (ReadData) begin
                        AccessErr <= 1'b1;
                    end
                    case (region_s)
                        REG_RAM: Leds <= Leds;
                        REG_LED: Leds <= DataOut;
                        REG_SW:  AccessErr <= 1'b1;
                        REG_BAD: AccessErr <= 1'b1;
                        default: AccessErr <= 1'b1;
                    endcase
                end else begin
                    case (region_s)
                        REG_RAM: DataIn <= ram_word_s;
                        REG_LED: DataIn <= Leds;
                        REG_SW:  DataIn <= Switches;
                        REG_BAD: begin
                            DataIn    <= {WORD_SIZE{1'b0}};
                            AccessErr <= 1'b1;
                        end
                        default: begin
                            DataIn    <= {WORD_SIZE{1'b0}};
                            AccessErr <= 1'b1;
                        end
                    endcase
                end
            end

            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        if (wait_s == 5'd0) begin
                            state_r   <= DONE;
                            counter_r <= 5'd0;
                        end else begin
                            state_r   <= BUSY;
                            counter_r <= wait_s - 5'd1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (!req_s) begin
                        // Processor withdrew the request: abandon without side effects.
                        state_r   <= IDLE;
                        counter_r <= 5'd0;
                    end else if (counter_r == 5'd0) begin
                        state_r <= DONE;
                    end else begin
                        counter_r <= counter_r - 5'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    counter_r <= 5'd0;
                end
            endcase
        end
    end

endmodule
